// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// operand-select encodings, the in-flight slot record and small match helpers.
package pipe_hazard_ctrl_pkg;

  // Widest register address a slot can hold; narrower addresses are zero-extended.
  localparam int MAX_REG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RET   = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  load;
  } slot_t;

  function automatic logic slot_match(input slot_t s, input logic en,
                                      input logic [MAX_REG_AW-1:0] src);
    return s.valid & en & (s.rd == src);
  endfunction

  // Youngest producer wins: the value still in EX is the most recent write.
  function automatic fwd_sel_e pick_sel(input logic m_ex, input logic m_mem,
                                        input logic m_wb);
    fwd_sel_e sel;
    if (m_ex)       sel = FWD_EXMEM;
    else if (m_mem) sel = FWD_MEMWB;
    else if (m_wb)  sel = FWD_RET;
    else            sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side bundle of the hazard controller: ID operand info in,
// stall/flush/forward controls and event counters out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rn;
  logic [REG_AW-1:0] id_rm;
  logic              id_rn_en;
  logic              id_rm_en;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_load;
  logic              ex_branch_taken;
  logic              stall_if;
  logic              bubble_ex;
  logic              flush_id;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_rn_en, id_rm_en, id_rd, id_wr_en,
           id_load, ex_branch_taken,
    input  stall_if, bubble_ex, flush_id, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_en, id_rm_en, id_rd, id_wr_en,
           id_load, ex_branch_taken,
    output stall_if, bubble_ex, flush_id, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles and sticks at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard, forwarding and branch-flush controller for the five-stage pipeline.
// Tracks destinations in EX/MEM/WB and either forwards or interlocks ID.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_hazard_ctrl_pkg::*;

  localparam logic FWD_ON = (FWD_EN != 0);

  slot_t ex_slot, mem_slot, wb_slot;

  logic [REG_AW-1:0]     id_rn, id_rm, id_rd;
  logic [MAX_REG_AW-1:0] rn_x, rm_x, rd_x;
  logic                  rn_ex, rn_mem, rn_wb;
  logic                  rm_ex, rm_mem, rm_wb;
  logic                  load_use, any_match, hazard;
  logic                  flush, stall, issue;
  fwd_sel_e              sel_a_next, sel_b_next;
  logic [1:0]            fwd_a_q, fwd_b_q;
  logic                  unused_wb_load;

  assign id_rn = bus.id_rn;
  assign id_rm = bus.id_rm;
  assign id_rd = bus.id_rd;
  assign rn_x  = MAX_REG_AW'(id_rn);
  assign rm_x  = MAX_REG_AW'(id_rm);
  assign rd_x  = MAX_REG_AW'(id_rd);

  assign rn_ex  = slot_match(ex_slot,  bus.id_rn_en, rn_x);
  assign rn_mem = slot_match(mem_slot, bus.id_rn_en, rn_x);
  assign rn_wb  = slot_match(wb_slot,  bus.id_rn_en, rn_x);
  assign rm_ex  = slot_match(ex_slot,  bus.id_rm_en, rm_x);
  assign rm_mem = slot_match(mem_slot, bus.id_rm_en, rm_x);
  assign rm_wb  = slot_match(wb_slot,  bus.id_rm_en, rm_x);

  // With forwarding only a load still in EX is unresolvable; without it any
  // in-flight producer blocks until it has retired.
  assign load_use  = (rn_ex | rm_ex) & ex_slot.load;
  assign any_match = rn_ex | rn_mem | rn_wb | rm_ex | rm_mem | rm_wb;
  assign hazard    = FWD_ON ? load_use : any_match;

  assign flush = bus.ex_branch_taken;
  assign stall = hazard & bus.id_valid & ~flush;
  assign issue = bus.id_valid & ~stall & ~flush;

  assign bus.stall_if  = stall;
  assign bus.bubble_ex = stall;
  assign bus.flush_id  = flush;

  assign sel_a_next = (FWD_ON && issue) ? pick_sel(rn_ex, rn_mem, rn_wb) : FWD_RF;
  assign sel_b_next = (FWD_ON && issue) ? pick_sel(rm_ex, rm_mem, rm_wb) : FWD_RF;

  // The branch in EX is killed on its way to MEM so its write never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= '{valid: ex_slot.valid & ~flush, rd: ex_slot.rd, load: ex_slot.load};
      ex_slot  <= '{valid: issue & bus.id_wr_en, rd: rd_x, load: bus.id_load};
      fwd_a_q  <= sel_a_next;
      fwd_b_q  <= sel_b_next;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;

  assign unused_wb_load = wb_slot.load;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (bus.stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, interlock-only and
// narrow-counter instances share one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) if_f ();
  pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) if_i ();
  pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(2))  if_s ();

  pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(1), .CNT_W(16)) dut_f (
    .clk (clk), .rst (rst), .bus (if_f.slave)
  );
  pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(0), .CNT_W(16)) dut_i (
    .clk (clk), .rst (rst), .bus (if_i.slave)
  );
  pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(1), .CNT_W(2)) dut_s (
    .clk (clk), .rst (rst), .bus (if_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rn, input logic rn_en,
                               input logic [3:0] rm, input logic rm_en,
                               input logic [3:0] rd, input logic wr, input logic ld,
                               input logic br);
    if_f.id_valid = v;  if_f.id_rn = rn;  if_f.id_rn_en = rn_en;
    if_f.id_rm = rm;    if_f.id_rm_en = rm_en;  if_f.id_rd = rd;
    if_f.id_wr_en = wr; if_f.id_load = ld;  if_f.ex_branch_taken = br;
    if_i.id_valid = v;  if_i.id_rn = rn;  if_i.id_rn_en = rn_en;
    if_i.id_rm = rm;    if_i.id_rm_en = rm_en;  if_i.id_rd = rd;
    if_i.id_wr_en = wr; if_i.id_load = ld;  if_i.ex_branch_taken = br;
    if_s.id_valid = v;  if_s.id_rn = rn;  if_s.id_rn_en = rn_en;
    if_s.id_rm = rm;    if_s.id_rm_en = rm_en;  if_s.id_rd = rd;
    if_s.id_wr_en = wr; if_s.id_load = ld;  if_s.ex_branch_taken = br;
  endtask

  task automatic issue(input logic [3:0] rd, input logic ld, input logic [3:0] rn,
                       input logic rn_en, input logic [3:0] rm, input logic rm_en);
    applyStimulus(1'b1, rn, rn_en, rm, rm_en, rd, 1'b1, ld, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  // Producer r1, gap unrelated writers, then a consumer reading r1 on rm.
  task automatic runDistance(input int gap, input logic [1:0] exp_b);
    doReset();
    issue(4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    for (int i = 0; i < gap; i++) begin
      issue(4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
    end
    issue(4'd6, 1'b0, 4'd2, 1'b1, 4'd1, 1'b1);
    @(negedge clk);
    checkOutput($sformatf("dist%0d_nostall", gap), if_f.stall_if, 0);
    tick();
    idle();
    @(negedge clk);
    checkOutput($sformatf("dist%0d_fwd_b", gap), if_f.fwd_b, exp_b);
    checkOutput($sformatf("dist%0d_fwd_a", gap), if_f.fwd_a, 0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every instance.
    @(negedge clk);
    checkOutput("rst_stall_if",  if_f.stall_if,  0);
    checkOutput("rst_bubble_ex", if_f.bubble_ex, 0);
    checkOutput("rst_flush_id",  if_f.flush_id,  0);
    checkOutput("rst_fwd_a",     if_f.fwd_a,     0);
    checkOutput("rst_fwd_b",     if_f.fwd_b,     0);
    checkOutput("rst_stall_cnt", if_f.stall_cnt, 0);
    checkOutput("rst_flush_cnt", if_f.flush_cnt, 0);
    checkOutput("rst_i_stall",   if_i.stall_if,  0);
    checkOutput("rst_s_cnt",     if_s.stall_cnt, 0);
    tick();

    // ADD r1 ; SUB r2,r1,r3 back-to-back.
    doReset();
    issue(4'd1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1);
    tick();
    issue(4'd2, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1);
    @(negedge clk);
    checkOutput("s1_stall_if", if_f.stall_if, 0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("s1_fwd_a", if_f.fwd_a, 1);
    checkOutput("s1_fwd_b", if_f.fwd_b, 0);
    tick();

    // Producer distance sweep.
    runDistance(0, 2'b01);
    runDistance(1, 2'b10);
    runDistance(2, 2'b11);
    runDistance(3, 2'b00);

    // LDR r4 ; ADD r5,r4,r4 : one stall then MEM_WB forwarding.
    doReset();
    issue(4'd4, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0);
    tick();
    issue(4'd5, 1'b0, 4'd4, 1'b1, 4'd4, 1'b1);
    @(negedge clk);
    checkOutput("s3_stall_if_1",  if_f.stall_if,  1);
    checkOutput("s3_bubble_ex_1", if_f.bubble_ex, 1);
    tick();
    @(negedge clk);
    checkOutput("s3_stall_if_2",  if_f.stall_if,  0);
    checkOutput("s3_bubble_ex_2", if_f.bubble_ex, 0);
    checkOutput("s3_fwd_a_stall", if_f.fwd_a,     0);
    checkOutput("s3_stall_cnt",   if_f.stall_cnt, 1);
    tick();
    idle();
    @(negedge clk);
    checkOutput("s3_fwd_a", if_f.fwd_a, 2);
    checkOutput("s3_fwd_b", if_f.fwd_b, 2);
    checkOutput("s3_stall_cnt_hold", if_f.stall_cnt, 1);
    tick();

    // Load-use coinciding with a taken branch: flush wins, load is killed.
    doReset();
    issue(4'd4, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("s4_stall_if",  if_f.stall_if,  0);
    checkOutput("s4_bubble_ex", if_f.bubble_ex, 0);
    checkOutput("s4_flush_id",  if_f.flush_id,  1);
    tick();
    issue(4'd5, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput("s4_flush_cnt",  if_f.flush_cnt, 1);
    checkOutput("s4_stall_cnt",  if_f.stall_cnt, 0);
    checkOutput("s4_no_stall",   if_f.stall_if,  0);
    checkOutput("s4_flush_drop", if_f.flush_id,  0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("s4_killed_fwd_a", if_f.fwd_a, 0);
    tick();

    // Interlock-only: adjacent RAW stalls for three cycles.
    doReset();
    issue(4'd1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1);
    tick();
    issue(4'd2, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("s5_stall_c%0d", c), if_i.stall_if, 1);
      checkOutput($sformatf("s5_fwd_a_c%0d", c), if_i.fwd_a, 0);
      tick();
    end
    @(negedge clk);
    checkOutput("s5_release",   if_i.stall_if,  0);
    checkOutput("s5_stall_cnt", if_i.stall_cnt, 3);
    tick();
    idle();
    @(negedge clk);
    checkOutput("s5_fwd_a_ex", if_i.fwd_a, 0);
    tick();

    // Interlock-only with reset asserted during the second stall cycle.
    doReset();
    issue(4'd1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1);
    tick();
    issue(4'd2, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s5r_stall_c2", if_i.stall_if, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("s5r_stall_if",  if_i.stall_if,  0);
    checkOutput("s5r_bubble_ex", if_i.bubble_ex, 0);
    checkOutput("s5r_flush_id",  if_i.flush_id,  0);
    checkOutput("s5r_fwd_a",     if_i.fwd_a,     0);
    checkOutput("s5r_stall_cnt", if_i.stall_cnt, 0);
    tick();

    // Continuous load-use stream: stalls every second cycle.
    doReset();
    issue(4'd4, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checkOutput("s6_narrow_cnt_2", if_s.stall_cnt, 2);
    tick();
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    checkOutput("s6_narrow_sat", if_s.stall_cnt, 3);
    checkOutput("s6_wide_cnt",   if_f.stall_cnt, 5);
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checkOutput("s6_narrow_hold", if_s.stall_cnt, 3);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the five-stage IF/ID/EX/MEM/WB processor pipeline. It tracks the destination register of every in-flight instruction in EX, MEM and WB, and resolves RAW hazards in one of two ways: by forwarding from later stages, or by holding fetch/decode and injecting bubbles. It also kills wrong-path instructions on a taken branch and keeps saturating stall/flush event counters. It sits beside the decoder and register file and drives the stall/flush controls of the IF_ID and ID_EX pipe registers and the EX operand muxes.

## Interface
- REG_AW, 4: register address width (16 architectural registers).
- FWD_EN, 1: 1 = forward where possible; 0 = interlock only (stall until producer has retired).
- CNT_W, 16: width of each event counter.

Reset is synchronous, active-high; one clock.

- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a live instruction.
- id_rn, id_rm  in  REG_AW  source addresses in ID.
- id_rn_en, id_rm_en  in  1  source actually read.
- id_rd  in  REG_AW  destination in ID.
- id_wr_en  in  1  instruction writes id_rd.
- id_load  in  1  instruction is a memory load (data available only at end of MEM).
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- stall_if  out  1  hold PC and IF_ID contents.
- bubble_ex  out  1  load NOP into ID_EX.
- flush_id  out  1  invalidate IF_ID at next edge.
- fwd_a, fwd_b  out  2  EX operand select, registered: 00 regfile, 01 EX_MEM result, 10 MEM_WB write data, 11 last-retired write data.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Tracker: three slots, EX, MEM and WB, each {valid, rd, load}.
- Each edge:
  - WB ← MEM.
  - MEM ← EX, with valid cleared if ex_branch_taken (the branching instruction's write is suppressed, matching the datapath).
  - EX ← ID when id_valid & id_wr_en & ~stall & ~flush; otherwise EX becomes invalid.
- Match(s, slot) = slot.valid & src_en & (src == slot.rd); evaluated for rn and rm independently.
- FWD_EN=1:
  - load-use = match against the EX slot with EX.load set → stall.
  - Otherwise the next-cycle select is chosen by youngest matching slot, priority EX > MEM > WB: EX → 01, MEM → 10, WB → 11, none → 00.
- FWD_EN=0: any match in any slot → stall; fwd_a and fwd_b stay 00.
- Stall condition: stall = hazard & id_valid & ~ex_branch_taken.
  - stall_if = stall; bubble_ex = stall.
  - While stalled, fwd selects load 00 (the bubble has no operands).
- Flush: flush_id = bubble_ex-independent copy of ex_branch_taken. Flush overrides stall: when both would assert, only flush_id and the EX bubble occur.
- Counters: stall_cnt increments on each stall cycle; flush_cnt increments on each ex_branch_taken cycle. Both saturate at 2^CNT_W−1 and do not wrap.
- Address 0 is an ordinary register; there is no hardwired-zero exemption.

## Timing
- stall_if, bubble_ex and flush_id are combinational from ID inputs and slot state, valid in the same cycle.
- fwd_a and fwd_b are registered: computed in the consumer's ID cycle and presented during its EX cycle.
- A load-use hazard costs exactly 1 stall cycle, then selects 10.
- An interlock-only hazard (FWD_EN=0) stalls until the producer has left WB: 3 cycles for an adjacent producer, 2 for a producer one instruction ahead, 1 for two ahead.
- Reset: all slots invalid; stall_if, bubble_ex and flush_id are 0; fwd selects 00; counters 0.
- Reset mid-stall releases the stall in the following cycle.
- rn and rm matching the same producer → both selects identical.
- A producer that is not id_wr_en never occupies a valid slot.

## Structure
- The shared pipeline package holds:
  - the fwd select encoding constants (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_RET);
  - the slot struct {valid, rd, load}.
- One natural sub-module, hazard_sat_counter (parametrised CNT_W, inc, rst), instantiated twice.
- Tracker, match logic and select registers stay in the top.

## Test plan
- Directed scenarios, each run under FWD_EN=1 unless stated:
  1. ADD r1 then SUB r2,r1,r3 back-to-back → no stall; fwd_a=01 during SUB's EX.
  2. Producer r1, one unrelated instruction, consumer rm=r1 → fwd_b=10. Two unrelated instructions in between → fwd_b=11. Three in between → 00.
  3. LDR r4 then ADD r5,r4,r4 → stall_if=bubble_ex=1 for exactly 1 cycle; then fwd_a=fwd_b=10; stall_cnt=1.
  4. Load-use hazard in the same cycle as ex_branch_taken → stall_if=0, flush_id=1, flush_cnt=1, stall_cnt unchanged; the killed load never forwards.
  5. FWD_EN=0, adjacent RAW → 3 consecutive stall cycles, fwd stays 00, stall_cnt=3. rst asserted in stall cycle 2 → all outputs 0 next cycle.
  6. CNT_W=2, continuous load-use stream → stall_cnt reaches 3 and holds.
